// File: rtl/obi_pkg.sv
// Minimal OBI type package: configuration record and default request/response structs
// sized for a 32-bit address/data bus with a 1-bit transaction id.
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic        a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

// File: rtl/user_obi_reader.sv
// OBI block reader: on start, fetches num_words consecutive 32-bit words with one
// transaction outstanding and streams each word out on a valid/ready port.
module user_obi_reader #(
  parameter obi_pkg::obi_cfg_t         ObiCfg        = obi_pkg::ObiDefaultConfig,
  parameter type                       obi_req_t     = obi_pkg::obi_req_t,
  parameter type                       obi_rsp_t     = obi_pkg::obi_rsp_t,
  parameter int unsigned               MaxWordsWidth = 16,
  parameter logic [ObiCfg.IdWidth-1:0] ReqId         = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [ObiCfg.AddrWidth-1:0] base_addr_i,
  input  logic [MaxWordsWidth-1:0]    num_words_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [31:0]                 data_o,
  output logic                        data_valid_o,
  input  logic                        data_ready_i,
  output obi_req_t                    obi_req_o,
  input  obi_rsp_t                    obi_rsp_i
);

  localparam int unsigned AW = ObiCfg.AddrWidth;

  typedef enum logic [2:0] {IDLE, REQ, RSP, OUT, DONE} state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            addr_q;
  logic [MaxWordsWidth-1:0] cnt_q;
  logic [31:0]              data_q;
  logic                     err_q;

  // rid and the optional response field carry nothing this reader needs.
  logic unused_rsp;
  assign unused_rsp = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (num_words_i == '0) ? DONE : REQ;
      REQ:     if (obi_rsp_i.gnt) state_d = RSP;
      RSP:     if (obi_rsp_i.rvalid) state_d = obi_rsp_i.r.err ? DONE : OUT;
      OUT:     if (data_ready_i) state_d = (cnt_q == MaxWordsWidth'(1)) ? DONE : REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q <= {base_addr_i[AW-1:2], 2'b00};
            cnt_q  <= num_words_i;
            err_q  <= 1'b0;
          end
        end
        RSP: begin
          if (obi_rsp_i.rvalid) begin
            if (obi_rsp_i.r.err) err_q  <= 1'b1;
            else                 data_q <= obi_rsp_i.r.rdata;
          end
        end
        OUT: begin
          // The address advances only after the consumer takes the word, so the
          // next request cannot overtake the stream.
          if (data_ready_i) begin
            cnt_q  <= cnt_q - MaxWordsWidth'(1);
            addr_q <= addr_q + AW'(4);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    obi_req_o         = '0;
    obi_req_o.req     = (state_q == REQ);
    obi_req_o.a.addr  = addr_q;
    obi_req_o.a.we    = 1'b0;
    obi_req_o.a.be    = '1;
    obi_req_o.a.wdata = '0;
    obi_req_o.a.aid   = ReqId;
  end

  assign busy_o       = (state_q == REQ) || (state_q == RSP) || (state_q == OUT);
  assign done_o       = (state_q == DONE);
  assign data_valid_o = (state_q == OUT);
  assign data_o       = data_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_user_obi_reader.sv
// Scoreboard bench for user_obi_reader: an OBI responder model answers reads with
// 0xA000_0000|addr, and a monitor compares every streamed word against a queue.
module tb_user_obi_reader;
  import obi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] num_words_i = '0;
  logic        busy_o, done_o, err_o, data_valid_o;
  logic [31:0] data_o;
  logic        data_ready_i = 1'b1;
  obi_req_t    obi_req;
  obi_rsp_t    obi_rsp;

  always #5 clk = ~clk;

  user_obi_reader dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .obi_req_o(obi_req), .obi_rsp_i(obi_rsp)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder model
  int   gnt_stall = 0;
  bit   rand_gnt = 0, rand_dly = 0;
  int   err_at = 0, grant_idx = 0, nogrant_cycles = 0;
  bit   pend = 0, pend_err = 0;
  int   pend_dly = 0;
  logic [31:0] pend_addr = '0;

  initial begin
    obi_rsp = '0;
    forever begin
      @(negedge clk);
      obi_rsp.rvalid = 1'b0;
      obi_rsp.r      = '0;
      if (!rst_ni) begin
        pend = 0;
        obi_rsp.gnt = 1'b1;
      end else begin
        if (pend) begin
          if (pend_dly == 0) begin
            obi_rsp.rvalid  = 1'b1;
            obi_rsp.r.rdata = 32'hA000_0000 | pend_addr;
            obi_rsp.r.err   = pend_err;
            pend = 0;
          end else pend_dly--;
        end
        if (gnt_stall > 0 && obi_req.req) begin
          obi_rsp.gnt = 1'b0;
          gnt_stall--;
        end else obi_rsp.gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        if (obi_req.req && !obi_rsp.gnt) nogrant_cycles++;
        if (obi_req.req && obi_rsp.gnt) begin
          grant_idx++;
          pend      = 1;
          pend_addr = obi_req.a.addr;
          pend_err  = (grant_idx == err_at);
          pend_dly  = rand_dly ? int'($urandom_range(0, 2)) : 0;
        end
      end
    end
  end

  // Consumer ready driver
  bit rand_ready = 0;
  int stall_word = -1, stall_left = 0, words_seen = 0;

  initial forever begin
    @(posedge clk); #1;
    if (data_valid_o && words_seen == stall_word && stall_left > 0) begin
      data_ready_i = 1'b0;
      stall_left--;
    end else data_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor
  int   done_cnt = 0, req_cycles = 0, stall_cycles = 0;
  logic prev_valid = 0, prev_ready = 0, prev_done = 0, prev_req_ng = 0;
  logic [31:0] prev_data = '0, prev_addr = '0;

  initial forever begin
    @(negedge clk); #1;
    if (!rst_ni) begin
      prev_valid = 0; prev_done = 0; prev_req_ng = 0;
    end else begin
      if (obi_req.req) req_cycles++;
      if (prev_req_ng) begin
        check("req_held", obi_req.req, 1);
        check("addr_held", obi_req.a.addr, prev_addr);
      end
      if (prev_valid && !prev_ready) begin
        check("valid_held", data_valid_o, 1);
        check("data_held", data_o, prev_data);
      end
      if (data_valid_o) check("req_while_valid", obi_req.req, 0);
      if (data_valid_o && !data_ready_i) stall_cycles++;
      if (data_valid_o && data_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_word: got %h, expected no word", data_o);
        end else check("data", data_o, exp_q.pop_front());
        words_seen++;
      end
      if (done_o) begin
        done_cnt++;
        check("busy_at_done", busy_o, 0);
        check("done_one_cycle", prev_done, 0);
      end
      prev_valid  = data_valid_o;
      prev_ready  = data_ready_i;
      prev_data   = data_o;
      prev_done   = done_o;
      prev_req_ng = obi_req.req && !obi_rsp.gnt;
      prev_addr   = obi_req.a.addr;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] base, input int n, input int err_idx);
    logic [31:0] a;
    a = {base[31:2], 2'b00};
    err_at = err_idx; grant_idx = 0; words_seen = 0;
    for (int i = 0; i < n; i++) begin
      if (err_idx == i + 1) break;
      exp_q.push_back(32'hA000_0000 | a);
      a = a + 32'd4;
    end
    base_addr_i = base; num_words_i = 16'(n); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] base, input int n);
    base_addr_i = base; num_words_i = 16'(n); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_seen", 32'(done_cnt != d0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, s0, ng0, lat, k, n, e;
    logic [31:0] b;

    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_valid", data_valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_req", obi_req.req, 0);
    check("rst_addr", obi_req.a.addr, 0);
    rst_ni = 1'b1;
    cyc(2);

    // Basic 3-word read with latency
    d0 = done_cnt;
    start_xfer(32'h100, 3, 0);
    check("req_after_start", obi_req.req, 1);
    check("req_be", obi_req.a.be, 4'hF);
    check("req_we", obi_req.a.we, 0);
    lat = 1;
    while (!data_valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_latency", lat, 3);
    wait_done(100);
    cyc(3);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_err", err_o, 0);
    check("t1_words_left", exp_q.size(), 0);

    // Back-pressure on word 2
    s0 = stall_cycles; stall_word = 1; stall_left = 5;
    start_xfer(32'h200, 3, 0);
    wait_done(100);
    check("bp_stall_cycles", stall_cycles - s0, 5);
    check("bp_words_left", exp_q.size(), 0);
    stall_word = -1;
    cyc(2);

    // Grant stall on first request
    ng0 = nogrant_cycles; gnt_stall = 4;
    start_xfer(32'h100, 2, 0);
    check("gs_addr", obi_req.a.addr, 32'h100);
    wait_done(100);
    check("gs_nogrant_cycles", nogrant_cycles - ng0, 4);
    check("gs_words_left", exp_q.size(), 0);
    cyc(2);

    // Error abort on 2nd of 4 words, then a new start clears err
    d0 = done_cnt;
    start_xfer(32'h300, 4, 2);
    wait_done(100);
    cyc(2);
    check("err_flag", err_o, 1);
    check("err_busy", busy_o, 0);
    check("err_done_count", done_cnt - d0, 1);
    check("err_words_left", exp_q.size(), 0);
    start_xfer(32'h40, 1, 0);
    check("err_cleared", err_o, 0);
    wait_done(100);
    cyc(2);

    // Zero words; start during DONE is ignored
    d0 = done_cnt; r0 = req_cycles;
    start_xfer(32'h500, 0, 0);
    check("zero_done_next_cycle", done_o, 1);
    pulse_start(32'h600, 2);
    cyc(5);
    check("zero_no_req", req_cycles - r0, 0);
    check("zero_done_count", done_cnt - d0, 1);
    check("zero_busy", busy_o, 0);

    // Start while busy is ignored
    d0 = done_cnt;
    start_xfer(32'h700, 3, 0);
    cyc(2);
    pulse_start(32'h900, 5);
    wait_done(100);
    cyc(5);
    check("busy_start_done_count", done_cnt - d0, 1);
    check("busy_start_idle", busy_o, 0);
    check("busy_start_words_left", exp_q.size(), 0);

    // Address wrap
    start_xfer(32'hFFFF_FFFC, 2, 0);
    wait_done(100);
    check("wrap_words_left", exp_q.size(), 0);
    cyc(2);

    // Reset while waiting for the response
    d0 = done_cnt;
    start_xfer(32'h200, 3, 0);
    k = 0;
    while (!(busy_o && !obi_req.req && !data_valid_o) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("rsp_state_reached", 32'(k < 20), 1);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_req", obi_req.req, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_done", done_o, 0);
    check("rst_mid_valid", data_valid_o, 0);
    exp_q.delete();
    cyc(2);
    rst_ni = 1'b1;
    cyc(4);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_idle", busy_o, 0);

    // Randomized transfers
    rand_ready = 1; rand_gnt = 1; rand_dly = 1;
    for (int t = 0; t < 12; t++) begin
      b = $urandom;
      n = int'($urandom_range(1, 5));
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
      start_xfer(b, n, e);
      wait_done(600);
      check("rand_err", err_o, 32'(e != 0));
      check("rand_words_left", exp_q.size(), 0);
      exp_q.delete();
      cyc(int'($urandom_range(1, 3)));
    end
    rand_ready = 0; rand_gnt = 0; rand_dly = 0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
